// File: rtl/smg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// smg_scan_ctrl
//
// Time-multiplexed scan controller for a 4-digit common-anode seven-segment
// display. It rotates the digit select and presents the matching 4-bit digit
// code to the downstream segment/digit decoder.
//
// Each digit slot is DIV_CNT cycles long. Its first BLANK_CYC cycles force the
// code to 4'hF so the previous digit cannot ghost onto the next one. A new
// 16-bit value is taken in through a request/acknowledge handshake and is
// committed only at a frame boundary, so one frame never mixes old and new
// digits.
//
// Optional feature:
//   SMG_LZB_EN  - leading-zero blanking. Digits 1..3 are blanked while they and
//                 every higher digit are zero. Digit 0 is always shown.
//
// Parameters:
//   DIV_CNT    clock cycles per digit slot (>= 4)
//   BLANK_CYC  blank cycles at the start of each slot (1 .. DIV_CNT-2)
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   en          scan enable; low blanks the display and parks the scan
//   upd_req     single-cycle request to load upd_data
//   upd_data    new display value, nibble i goes to digit i
//   upd_ack     one-cycle pulse when a value reaches the display register
//   sel         digit index 0..3 (0 = rightmost)
//   key         digit code to the decoder, 4'hF = blank
//   frame_done  one-cycle pulse marking the end of the digit-3 slot
// -----------------------------------------------------------------------------
module smg_scan_ctrl #(
    parameter int DIV_CNT   = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        upd_req,
    input  logic [15:0] upd_data,
    output logic        upd_ack,
    output logic [1:0]  sel,
    output logic [3:0]  key,
    output logic        frame_done
);

    localparam int            CW        = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV_CNT - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
    localparam logic [CW-1:0] DIV_ONE   = CW'(1);
    localparam logic [3:0]    KEY_BLANK = 4'hF;

    logic [CW-1:0] div_cnt;
    logic [15:0]   disp_reg;
    logic [15:0]   pend_reg;
    logic          pend_vld;

    logic [CW-1:0] div_nx;
    logic [1:0]    sel_nx;
    logic [15:0]   disp_nx;
    logic [15:0]   pend_nx;
    logic          pend_vld_nx;
    logic          ack_nx;
    logic          slot_end;
    logic          boundary;
    logic [3:0]    nibble;
    logic [3:0]    lead_zero;
    logic [3:0]    key_nx;

    // Next-state of the scan position and of the display/pending registers.
    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        slot_end    = (div_cnt == DIV_LAST);
        boundary    = en && slot_end && (sel == 2'd3);

        div_nx      = div_cnt;
        sel_nx      = sel;
        disp_nx     = disp_reg;
        pend_nx     = pend_reg;
        pend_vld_nx = pend_vld;
        ack_nx      = 1'b0;

        if (!en) begin
            div_nx = '0;
            sel_nx = 2'd0;
        end else if (slot_end) begin
            div_nx = '0;
            sel_nx = sel + 2'd1;
        end else begin
            div_nx = div_cnt + DIV_ONE;
        end

        // A waiting value is committed as the frame wraps.
        if (boundary && pend_vld) begin
            disp_nx     = pend_reg;
            pend_vld_nx = 1'b0;
            ack_nx      = 1'b1;
        end

        // A request on the boundary itself, or while the scan is parked, has
        // no frame to tear, so it goes straight to the display register and
        // supersedes anything pending. Otherwise it waits; last request wins.
        if (upd_req) begin
            if (!en || boundary) begin
                disp_nx     = upd_data;
                pend_vld_nx = 1'b0;
                ack_nx      = 1'b1;
            end else begin
                pend_nx     = upd_data;
                pend_vld_nx = 1'b1;
            end
        end
    end

    // The digit code is computed from the next scan position and next display
    // value, so the registered key always belongs to the registered sel.
    always_comb begin
        nibble = disp_nx[3:0];
        case (sel_nx)
            2'd0:    nibble = disp_nx[3:0];
            2'd1:    nibble = disp_nx[7:4];
            2'd2:    nibble = disp_nx[11:8];
            default: nibble = disp_nx[15:12];
        endcase

        // lead_zero[i]: nibble i and all higher nibbles are zero.
        // Digit 0 never qualifies, so a zero value still shows one "0".
        lead_zero[3] = (disp_nx[15:12] == 4'h0);
        lead_zero[2] = lead_zero[3] && (disp_nx[11:8] == 4'h0);
        lead_zero[1] = lead_zero[2] && (disp_nx[7:4] == 4'h0);
        lead_zero[0] = 1'b0;

        key_nx = KEY_BLANK;
        if (en && (div_nx >= BLANK_END)) begin
`ifdef SMG_LZB_EN
            key_nx = lead_zero[sel_nx] ? KEY_BLANK : nibble;
`else
            key_nx = nibble;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt    <= '0;
            sel        <= 2'd0;
            key        <= KEY_BLANK;
            disp_reg   <= 16'h0000;
            pend_vld   <= 1'b0;
            upd_ack    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            div_cnt    <= div_nx;
            sel        <= sel_nx;
            key        <= key_nx;
            disp_reg   <= disp_nx;
            pend_vld   <= pend_vld_nx;
            upd_ack    <= ack_nx;
            frame_done <= boundary;
        end
    end

    // NOTE: the pending data word carries no reset; it is only ever read while
    // pend_vld is set, and pend_vld is reset.
    always_ff @(posedge clk) begin
        pend_reg <= pend_nx;
    end

endmodule

// File: tb/tb_smg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_smg_scan_ctrl
//
// Scoreboard bench for smg_scan_ctrl with DIV_CNT=8, BLANK_CYC=2. The stimulus
// process drives directed vectors at falling edges and pushes the expected
// responses (cycle of each upd_ack / frame_done pulse, and sel/key samples)
// into queues. An independent monitor pops and compares them at every falling
// edge. Cycle numbers count rising edges since time zero.
// -----------------------------------------------------------------------------
module tb_smg_scan_ctrl;

    localparam int DIV = 8;
    localparam int BLK = 2;
    localparam int FRM = 4 * DIV;

`ifdef SMG_LZB_EN
    localparam logic [3:0] ZB = 4'hF;  // leading zero digit appears blank
`else
    localparam logic [3:0] ZB = 4'h0;  // leading zero digit shown as 0
`endif

    typedef struct {
        int         t;
        logic [1:0] sel;
        logic [3:0] key;
    } key_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        upd_req = 1'b0;
    logic [15:0] upd_data = 16'h0000;
    logic        upd_ack;
    logic [1:0]  sel;
    logic [3:0]  key;
    logic        frame_done;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int t0, t1, t2;

    key_exp_t exp_key[$];
    int       exp_ack[$];
    int       exp_fd[$];
    key_exp_t mon_e;

    smg_scan_ctrl #(
        .DIV_CNT   (DIV),
        .BLANK_CYC (BLK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .upd_req    (upd_req),
        .upd_data   (upd_data),
        .upd_ack    (upd_ack),
        .sel        (sel),
        .key        (key),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic push_key(input int t, input logic [1:0] s, input logic [3:0] k);
        key_exp_t e;
        e.t   = t;
        e.sel = s;
        e.key = k;
        exp_key.push_back(e);
    endtask

    // Expected sel/key for positions 1..last of a frame starting at cycle base:
    // blank for the first BLK cycles of each slot, digit code afterwards.
    task automatic push_frame(input int base, input logic [3:0] k0, input logic [3:0] k1,
                              input logic [3:0] k2, input logic [3:0] k3, input int last);
        logic [3:0] ks [4];
        ks[0] = k0;
        ks[1] = k1;
        ks[2] = k2;
        ks[3] = k3;
        for (int p = 1; p <= last; p++) begin
            push_key(base + p, 2'(p / DIV), ((p % DIV) < BLK) ? 4'hF : ks[p / DIV]);
        end
    endtask

    task automatic pulse_req(input logic [15:0] d);
        upd_req  = 1'b1;
        upd_data = d;
        @(negedge clk);
        upd_req  = 1'b0;
    endtask

    // Monitor: compares whatever the DUT presents against the queues.
    always @(negedge clk) begin
        if (exp_ack.size() > 0 && exp_ack[0] == cyc) begin
            check("upd_ack", 32'(upd_ack), 32'd1);
            void'(exp_ack.pop_front());
        end else if (upd_ack === 1'b1) begin
            check("upd_ack_spurious", 32'(upd_ack), 32'd0);
        end

        if (exp_fd.size() > 0 && exp_fd[0] == cyc) begin
            check("frame_done", 32'(frame_done), 32'd1);
            void'(exp_fd.pop_front());
        end else if (frame_done === 1'b1) begin
            check("frame_done_spurious", 32'(frame_done), 32'd0);
        end

        if (exp_key.size() > 0 && exp_key[0].t == cyc) begin
            mon_e = exp_key.pop_front();
            check("sel", 32'(sel), 32'(mon_e.sel));
            check("key", 32'(key), 32'(mon_e.key));
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state.
        push_key(2, 2'd0, 4'hF);
        push_key(3, 2'd0, 4'hF);

        // Frame 0: display 0000.
        wait_cyc(4);
        t0  = cyc;
        rst = 1'b0;
        en  = 1'b1;
        push_frame(t0, 4'h0, ZB, ZB, ZB, FRM - 1);
        for (int k = 1; k <= 5; k++) exp_fd.push_back(t0 + k * FRM);

        // Mid-frame update at sel=1, div_cnt=3; committed at the next boundary.
        wait_cyc(t0 + FRM + DIV + 3);
        exp_ack.push_back(t0 + 2 * FRM);
        push_frame(t0 + 2 * FRM, 4'h4, 4'h3, 4'h2, 4'h1, FRM - 1);
        pulse_req(16'h1234);

        // Two requests in one frame: last wins, single ack.
        wait_cyc(t0 + 2 * FRM + 5);
        exp_ack.push_back(t0 + 3 * FRM);
        push_frame(t0 + 3 * FRM, 4'h2, 4'h2, 4'h2, 4'h2, FRM - 1);
        pulse_req(16'h1111);
        wait_cyc(t0 + 2 * FRM + 20);
        pulse_req(16'h2222);

        // Pending value later superseded by a bypass on the boundary cycle.
        wait_cyc(t0 + 3 * FRM + 14);
        pulse_req(16'h5555);
        wait_cyc(t0 + 4 * FRM - 1);
        exp_ack.push_back(t0 + 4 * FRM);
        push_frame(t0 + 4 * FRM, 4'h9, 4'h0, 4'hA, ZB, FRM - 1);
        pulse_req(16'h0A09);

        // Drop en mid-slot (sel=1, div_cnt=2).
        wait_cyc(t0 + 5 * FRM + 10);
        en = 1'b0;
        push_key(t0 + 5 * FRM + 11, 2'd0, 4'hF);
        push_key(t0 + 5 * FRM + 12, 2'd0, 4'hF);

        // Update while disabled: immediate load, ack next cycle.
        wait_cyc(t0 + 5 * FRM + 12);
        exp_ack.push_back(t0 + 5 * FRM + 13);
        pulse_req(16'h0777);

        // Re-enable: scan restarts at sel=0, div_cnt=0.
        wait_cyc(t0 + 5 * FRM + 15);
        t1 = cyc;
        en = 1'b1;
        push_frame(t1, 4'h7, 4'h7, 4'h7, ZB, 18);

        // Reset with an update pending: no ack, display returns to 0000.
        wait_cyc(t1 + 10);
        pulse_req(16'h4321);
        wait_cyc(t1 + 20);
        rst = 1'b1;
        push_key(t1 + 21, 2'd0, 4'hF);
        push_key(t1 + 22, 2'd0, 4'hF);
        push_key(t1 + 23, 2'd0, 4'hF);
        wait_cyc(t1 + 24);
        rst = 1'b0;
        t2  = cyc;
        push_frame(t2, 4'h0, ZB, ZB, ZB, FRM - 1);
        exp_fd.push_back(t2 + FRM);
        wait_cyc(t2 + FRM + 8);

        check("exp_ack_left", 32'(exp_ack.size()), 32'd0);
        check("exp_fd_left", 32'(exp_fd.size()), 32'd0);
        check("exp_key_left", 32'(exp_key.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
